// File: rtl/cps2_sync_monitor.sv
// cps2_sync_monitor
//   Watches the raw CPS2 HSYNC/VSYNC pair, measures dots per line and lines
//   per frame, and runs a lock state machine. The frontend output is enabled
//   only while the incoming timing has been a valid CPS2 mode for
//   LOCK_FRAMES consecutive frames.
//
// Ports
//   PCLK_i        pixel clock (2x dot clock), the only clock
//   reset_n       synchronous active-low reset
//   HSYNC_i       raw active-low horizontal sync, synchronous to PCLK_i
//   VSYNC_i       raw active-low vertical sync, synchronous to PCLK_i
//   enable_i      CPU enable; low forces IDLE
//   meas_h_total  last measured line length, in dots
//   meas_v_total  last measured frame length, in lines
//   locked        state == LOCKED
//   out_en        frontend output enable (same as locked)
//   lock_lost     one-cycle pulse when LOCKED is left because of a fault
//   state_o       IDLE=0, SEARCH=1, VERIFY=2, LOCKED=3
module cps2_sync_monitor #(
  parameter int H_TOTAL_EXP = 512,
  parameter int V_TOTAL_EXP = 262,
  parameter int H_TOL       = 4,
  parameter int V_TOL       = 2,
  parameter int LOCK_FRAMES = 4
) (
  input  logic       PCLK_i,
  input  logic       reset_n,
  input  logic       HSYNC_i,
  input  logic       VSYNC_i,
  input  logic       enable_i,
  output logic [9:0] meas_h_total,
  output logic [9:0] meas_v_total,
  output logic       locked,
  output logic       out_en,
  output logic       lock_lost,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam logic [10:0] H_EXP   = 11'(H_TOTAL_EXP);
  localparam logic [10:0] V_EXP   = 11'(V_TOTAL_EXP);
  localparam logic [10:0] H_TOL_W = 11'(H_TOL);
  localparam logic [10:0] V_TOL_W = 11'(V_TOL);
  localparam logic [10:0] V_MAX   = 11'(V_TOTAL_EXP + V_TOL);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  state_t      state_q, state_d;
  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic [10:0] pclk_cnt_q, pclk_cnt_d;
  logic [9:0]  line_cnt_q, line_cnt_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic        first_h_q, first_h_d;
  logic [9:0]  meas_h_q, meas_h_d;
  logic [9:0]  meas_v_q, meas_v_d;
  logic        lock_lost_q, lock_lost_d;

  logic        hedge, fstart;
  logic [10:0] h_meas, v_meas, h_diff, v_diff;
  logic        h_ok, v_ok;
  logic        h_fault, v_fault, overrun, timeout, fault;
  logic [3:0]  good_inc;

  // Edge detection, measurement and fault decode.
  always_comb begin
    hedge   = hs_prev_q & ~HSYNC_i;
    // vs_prev only moves on line edges, so this is a once-per-line sample.
    fstart  = hedge & vs_prev_q & ~VSYNC_i;

    h_meas  = {1'b0, pclk_cnt_q[10:1]};
    v_meas  = {1'b0, line_cnt_q} + 11'd1;
    // Absolute difference without wrap: subtract the smaller from the larger.
    h_diff  = (h_meas >= H_EXP) ? (h_meas - H_EXP) : (H_EXP - h_meas);
    v_diff  = (v_meas >= V_EXP) ? (v_meas - V_EXP) : (V_EXP - v_meas);
    h_ok    = (h_diff <= H_TOL_W);
    v_ok    = (v_diff <= V_TOL_W);

    h_fault = hedge & ~first_h_q & ~h_ok;
    v_fault = fstart & ~v_ok;
    // Fires on the edge that would push line_cnt past the allowed maximum.
    overrun = hedge & ~fstart & ({1'b0, line_cnt_q} >= V_MAX);
    timeout = &pclk_cnt_q;
    fault   = h_fault | v_fault | overrun | timeout;
  end

  // Counters and measurement registers.
  always_comb begin
    hs_prev_d  = HSYNC_i;
    vs_prev_d  = hedge ? VSYNC_i : vs_prev_q;
    pclk_cnt_d = pclk_cnt_q;
    line_cnt_d = line_cnt_q;
    first_h_d  = first_h_q;
    meas_h_d   = meas_h_q;
    meas_v_d   = meas_v_q;

    if (state_q == ST_IDLE) begin
      pclk_cnt_d = '0;
      line_cnt_d = '0;
      first_h_d  = 1'b1;
    end else begin
      if (hedge) begin
        pclk_cnt_d = 11'd1;
        meas_h_d   = pclk_cnt_q[10:1];
        first_h_d  = 1'b0;
      end else if (!timeout) begin
        pclk_cnt_d = pclk_cnt_q + 11'd1;
      end

      if (fstart) begin
        line_cnt_d = '0;
        meas_v_d   = v_meas[9:0];
      end else if (hedge && (line_cnt_q != 10'h3FF)) begin
        line_cnt_d = line_cnt_q + 10'd1;
      end
    end
  end

  // Lock state machine.
  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    lock_lost_d = 1'b0;
    good_inc    = good_cnt_q + 4'd1;

    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SEARCH;
        ST_SEARCH: begin
          // The partial frame before the first frame start is never judged.
          if (fstart) begin
            state_d    = ST_VERIFY;
            good_cnt_d = '0;
          end
        end
        ST_VERIFY: begin
          if (fault) begin
            state_d = ST_SEARCH;
          end else if (fstart) begin
            good_cnt_d = good_inc;
            if (good_inc == LOCK_N) state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (fault) begin
            state_d     = ST_SEARCH;
            lock_lost_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK_i) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      hs_prev_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
      pclk_cnt_q  <= '0;
      line_cnt_q  <= '0;
      good_cnt_q  <= '0;
      first_h_q   <= 1'b1;
      meas_h_q    <= '0;
      meas_v_q    <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hs_prev_q   <= hs_prev_d;
      vs_prev_q   <= vs_prev_d;
      pclk_cnt_q  <= pclk_cnt_d;
      line_cnt_q  <= line_cnt_d;
      good_cnt_q  <= good_cnt_d;
      first_h_q   <= first_h_d;
      meas_h_q    <= meas_h_d;
      meas_v_q    <= meas_v_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign state_o      = state_q;
  assign locked       = (state_q == ST_LOCKED);
  assign out_en       = locked;
  assign lock_lost    = lock_lost_q;
  assign meas_h_total = meas_h_q;
  assign meas_v_total = meas_v_q;

endmodule

// File: tb/tb_cps2_sync_monitor.sv
module tb_cps2_sync_monitor;
  localparam int HE  = 20;
  localparam int VE  = 10;
  localparam int HT  = 4;
  localparam int VT  = 2;
  localparam int LF  = 4;
  localparam int NOM = 2 * HE;
  localparam int HSW = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs = 1'b1, vs = 1'b1, en = 1'b0;
  logic [9:0] mh, mv;
  logic       lk, oe, ll;
  logic [1:0] st;

  cps2_sync_monitor #(
    .H_TOTAL_EXP(HE), .V_TOTAL_EXP(VE), .H_TOL(HT), .V_TOL(VT), .LOCK_FRAMES(LF)
  ) dut (
    .PCLK_i(clk), .reset_n(rst_n), .HSYNC_i(hs), .VSYNC_i(vs), .enable_i(en),
    .meas_h_total(mh), .meas_v_total(mv), .locked(lk), .out_en(oe),
    .lock_lost(ll), .state_o(st)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;

  // monitor
  int cyc = 0, n_lost, lost_cyc, lock_rise_cyc, last_he, diff_cnt;
  bit lost_oe, saw_lock, saw_verify;
  string diff_info;
  int fs_cyc[$];

  // reference model (states: 0 idle, 1 search, 2 verify, 3 locked)
  bit m_hs, m_vs, m_first, e_lost;
  int m_pc, m_lc, m_st, m_good, e_h, e_v;

  task automatic model_step();
    bit he, fs, flt;
    int hm, vm, nst;
    if (!rst_n) begin
      m_hs = 0; m_vs = 0; m_first = 1; m_pc = 0; m_lc = 0; m_st = 0; m_good = 0;
      e_h = 0; e_v = 0; e_lost = 0;
      return;
    end
    he  = m_hs && !hs;
    fs  = he && m_vs && !vs;
    hm  = m_pc / 2;
    vm  = m_lc + 1;
    flt = (he && !m_first && (hm > HE + HT || hm < HE - HT))
       || (fs && (vm > VE + VT || vm < VE - VT))
       || (he && !fs && (m_lc + 1 > VE + VT))
       || (m_pc == 2047);
    e_lost = 0;
    nst = m_st;
    if (!en) nst = 0;
    else if (m_st == 0) nst = 1;
    else if (m_st == 1) begin
      if (fs) begin nst = 2; m_good = 0; end
    end else if (flt) begin
      if (m_st == 3) e_lost = 1;
      nst = 1;
    end else if (m_st == 2 && fs) begin
      m_good++;
      if (m_good == LF) nst = 3;
    end
    if (m_st == 0) begin
      m_pc = 0; m_lc = 0; m_first = 1;
    end else begin
      if (he) begin e_h = hm; m_pc = 1; m_first = 0; end
      else if (m_pc < 2047) m_pc++;
      if (fs) begin e_v = vm % 1024; m_lc = 0; end
      else if (he && m_lc < 1023) m_lc++;
    end
    m_hs = hs;
    if (he) m_vs = vs;
    m_st = nst;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (ll === 1'b1) begin n_lost++; lost_cyc = cyc; lost_oe = oe; end
    if (lk === 1'b1) begin
      saw_lock = 1;
      if (lock_rise_cyc < 0) lock_rise_cyc = cyc;
    end
    if (st === 2'd2) saw_verify = 1;
    if (st !== 2'(m_st) || mh !== 10'(e_h) || mv !== 10'(e_v) ||
        lk !== (m_st == 3) || oe !== (m_st == 3) || ll !== e_lost) begin
      if (diff_cnt == 0)
        diff_info = $sformatf("cyc %0d st=%0d/%0d mh=%0d/%0d mv=%0d/%0d lk=%b oe=%b ll=%b/%b",
                              cyc, st, m_st, mh, e_h, mv, e_v, lk, oe, ll, e_lost);
      diff_cnt++;
    end
  endtask

  task automatic clr_mon();
    n_lost = 0; lost_cyc = -1; lock_rise_cyc = -1; lost_oe = 1;
    saw_lock = 0; saw_verify = 0; diff_cnt = 0; diff_info = "";
    fs_cyc.delete();
  endtask

  task automatic line(input int len, input bit vlow);
    hs = 1'b0;
    vs = vlow ? 1'b0 : 1'b1;
    last_he = cyc + 1;
    for (int i = 0; i < len; i++) begin
      if (i == HSW) hs = 1'b1;
      tick();
    end
  endtask

  task automatic frame(input int nl, input int len, input int last_len);
    fs_cyc.push_back(cyc + 1);
    for (int l = 0; l < nl; l++) line((l == nl - 1) ? last_len : len, l < 3);
  endtask

  task automatic lead_in(input int len);
    for (int l = 0; l < 3; l++) line(len, 1'b0);
  endtask

  task automatic restart();
    rst_n = 1'b0; en = 1'b1; hs = 1'b1; vs = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    clr_mon();
  endtask

  task automatic lock_up();
    restart();
    lead_in(NOM);
    for (int f = 0; f < 5; f++) frame(VE, NOM, NOM);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    clr_mon();
    tick(); tick();
    n_tot++; if (st !== 2'd0) $display("FAIL reset_state got %0d want 0", st); else n_pass++;
    n_tot++; if (mh !== 10'd0) $display("FAIL reset_meas_h got %0d want 0", mh); else n_pass++;
    n_tot++; if (mv !== 10'd0) $display("FAIL reset_meas_v got %0d want 0", mv); else n_pass++;
    n_tot++; if (lk !== 1'b0) $display("FAIL reset_locked got %b want 0", lk); else n_pass++;
    n_tot++; if (oe !== 1'b0) $display("FAIL reset_out_en got %b want 0", oe); else n_pass++;
    n_tot++; if (ll !== 1'b0) $display("FAIL reset_lock_lost got %b want 0", ll); else n_pass++;
  endtask

  task automatic test_nominal();
    lock_up();
    frame(VE, NOM, NOM);
    n_tot++; if (mh !== 10'(HE)) $display("FAIL nom_meas_h got %0d want %0d", mh, HE); else n_pass++;
    n_tot++; if (mv !== 10'(VE)) $display("FAIL nom_meas_v got %0d want %0d", mv, VE); else n_pass++;
    n_tot++; if (lk !== 1'b1 || oe !== 1'b1) $display("FAIL nom_locked got %b/%b want 1/1", lk, oe); else n_pass++;
    n_tot++; if (lock_rise_cyc !== fs_cyc[4]) $display("FAIL nom_lock_cycle got %0d want %0d", lock_rise_cyc, fs_cyc[4]); else n_pass++;
    n_tot++; if (n_lost !== 0) $display("FAIL nom_no_lost got %0d pulses want 0", n_lost); else n_pass++;
    n_tot++; if (diff_cnt !== 0) $display("FAIL nom_model got %0d diffs want 0 (%s)", diff_cnt, diff_info); else n_pass++;
  endtask

  task automatic run_case(input string nm, input int len, input int nl, input bit exp_lock, input bit exp_alt);
    restart();
    lead_in(len);
    for (int f = 0; f < 6; f++) frame(nl, len, len);
    n_tot++; if (saw_lock !== exp_lock) $display("FAIL %s_lock got %b want %b", nm, saw_lock, exp_lock); else n_pass++;
    if (exp_alt) begin
      n_tot++; if (saw_verify !== 1'b1) $display("FAIL %s_alternate got verify_seen=%b want 1", nm, saw_verify); else n_pass++;
    end
    n_tot++; if (diff_cnt !== 0) $display("FAIL %s_model got %0d diffs want 0 (%s)", nm, diff_cnt, diff_info); else n_pass++;
  endtask

  task automatic test_tolerance();
    run_case("h_edge_ok",  2 * (HE + HT),     VE,          1'b1, 1'b0);
    run_case("h_edge_bad", 2 * (HE + HT) + 2, VE,          1'b0, 1'b1);
    run_case("h_low_ok",   2 * (HE - HT),     VE,          1'b1, 1'b0);
    run_case("v_edge_ok",  NOM,               VE + VT,     1'b1, 1'b0);
    run_case("v_edge_bad", NOM,               VE + VT + 1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      int len, nl, dh, dv;
      bit ok;
      len = $urandom_range(2 * (HE + HT) + 4, 2 * (HE - HT) - 4);
      nl  = $urandom_range(VE + VT + 1, VE - VT - 1);
      dh  = (len / 2 > HE) ? len / 2 - HE : HE - len / 2;
      dv  = (nl > VE) ? nl - VE : VE - nl;
      ok  = (dh <= HT) && (dv <= VT);
      run_case($sformatf("rand%0d_len%0d_nl%0d", k, len, nl), len, nl, ok, 1'b0);
    end
  endtask

  task automatic test_sync_loss();
    int he, k;
    lock_up();
    he = last_he;
    k = 0;
    while (n_lost == 0 && k < 2200) begin tick(); k++; end
    tick(); tick(); tick();
    n_tot++; if (n_lost !== 1) $display("FAIL loss_pulses got %0d want 1", n_lost); else n_pass++;
    n_tot++; if (lost_cyc !== he + 2047) $display("FAIL loss_cycle got %0d want %0d", lost_cyc, he + 2047); else n_pass++;
    n_tot++; if (lost_oe !== 1'b0) $display("FAIL loss_out_en got %b want 0", lost_oe); else n_pass++;
    n_tot++; if (st !== 2'd1) $display("FAIL loss_state got %0d want 1", st); else n_pass++;
    n_tot++; if (diff_cnt !== 0) $display("FAIL loss_model got %0d diffs want 0 (%s)", diff_cnt, diff_info); else n_pass++;
  endtask

  task automatic test_overrun();
    int exp_cyc;
    lock_up();
    exp_cyc = -2;
    for (int l = 0; l < VE + VT + 4; l++) begin
      line(NOM, l < 3);
      if (l == VE + VT + 1) exp_cyc = last_he;
    end
    n_tot++; if (n_lost !== 1) $display("FAIL ovr_pulses got %0d want 1", n_lost); else n_pass++;
    n_tot++; if (lost_cyc !== exp_cyc) $display("FAIL ovr_cycle got %0d want %0d", lost_cyc, exp_cyc); else n_pass++;
    n_tot++; if (st !== 2'd1) $display("FAIL ovr_state got %0d want 1", st); else n_pass++;
    n_tot++; if (diff_cnt !== 0) $display("FAIL ovr_model got %0d diffs want 0 (%s)", diff_cnt, diff_info); else n_pass++;
  endtask

  task automatic test_disable();
    lock_up();
    en = 1'b0;
    tick();
    n_tot++; if (st !== 2'd0) $display("FAIL dis_state got %0d want 0", st); else n_pass++;
    n_tot++; if (oe !== 1'b0 || lk !== 1'b0) $display("FAIL dis_out_en got %b/%b want 0/0", oe, lk); else n_pass++;
    tick(); tick();
    n_tot++; if (n_lost !== 0) $display("FAIL dis_no_lost got %0d pulses want 0", n_lost); else n_pass++;
    en = 1'b1;
    tick();
    fs_cyc.delete(); lock_rise_cyc = -1;
    for (int f = 0; f < 6; f++) frame(VE, NOM, NOM);
    n_tot++; if (lock_rise_cyc !== fs_cyc[4]) $display("FAIL dis_relock got %0d want %0d", lock_rise_cyc, fs_cyc[4]); else n_pass++;
    n_tot++; if (diff_cnt !== 0) $display("FAIL dis_model got %0d diffs want 0 (%s)", diff_cnt, diff_info); else n_pass++;
  endtask

  task automatic test_reset_mid();
    lock_up();
    rst_n = 1'b0;
    tick();
    n_tot++; if ({st, mh, mv, lk, oe, ll} !== 25'd0)
      $display("FAIL rstmid_outputs got st=%0d mh=%0d mv=%0d lk=%b oe=%b ll=%b want all 0", st, mh, mv, lk, oe, ll);
    else n_pass++;
    rst_n = 1'b1;
    clr_mon();
    lead_in(NOM);
    for (int f = 0; f < 6; f++) frame(VE, NOM, NOM);
    n_tot++; if (lock_rise_cyc !== fs_cyc[4]) $display("FAIL rstmid_relock got %0d want %0d", lock_rise_cyc, fs_cyc[4]); else n_pass++;
    n_tot++; if (n_lost !== 0) $display("FAIL rstmid_no_lost got %0d want 0", n_lost); else n_pass++;
  endtask

  task automatic test_simultaneous();
    restart();
    lead_in(NOM);
    for (int f = 0; f < 3; f++) frame(VE, NOM, NOM);
    frame(VE, NOM, 2 * (HE + 8));
    line(NOM, 1'b1);
    n_tot++; if (st !== 2'd1) $display("FAIL simul_state got %0d want 1", st); else n_pass++;
    n_tot++; if (saw_lock !== 1'b0) $display("FAIL simul_no_lock got %b want 0", saw_lock); else n_pass++;
    n_tot++; if (mh !== 10'(HE + 8)) $display("FAIL simul_meas_h got %0d want %0d", mh, HE + 8); else n_pass++;
    n_tot++; if (diff_cnt !== 0) $display("FAIL simul_model got %0d diffs want 0 (%s)", diff_cnt, diff_info); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_tolerance();
    test_random();
    test_sync_loss();
    test_overrun();
    test_disable();
    test_reset_mid();
    test_simultaneous();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
